adv_timer_sequencer: RTL and testbench

Command and run-state controller for one up/down timer counter channel. Turns register-level command pulses (start, stop, arm, update, reset) and an external trigger into the counter's ctrl_active/ctrl_update/ctrl_rst controls. Counts completed counter periods and auto-stops after a programmed repeat count. Sits between the APB register file and the counter instance of each timer channel.

---
 rtl/adv_timer_sequencer.sv | 119 +++++++++++
 tb/tb_adv_timer_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/adv_timer_sequencer.sv
// Run-state controller for one timer channel: turns command pulses and the external
// trigger into counter enable/update/reset controls and counts completed periods.
module adv_timer_sequencer #(
  parameter int unsigned RPT_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                cmd_start_i,
  input  logic                cmd_stop_i,
  input  logic                cmd_arm_i,
  input  logic                cmd_update_i,
  input  logic                cmd_reset_i,
  input  logic                trig_i,
  input  logic                counter_end_i,
  input  logic [RPT_BITS-1:0] cfg_repeat_i,
  output logic                ctrl_active_o,
  output logic                ctrl_update_o,
  output logic                ctrl_rst_o,
  output logic [1:0]          state_o,
  output logic [RPT_BITS-1:0] period_cnt_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_RUN   = 2'b10
  } state_e;

  localparam logic [RPT_BITS-1:0] CNT_ZERO = {RPT_BITS{1'b0}};
  localparam logic [RPT_BITS-1:0] CNT_ONE  = {{(RPT_BITS-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [RPT_BITS-1:0] cnt_q, cnt_d, cnt_nxt_s, cnt_inc_s;
  logic                active_q, active_d;
  logic                update_q, rst_q;
  logic                done_q, done_d;

  assign cnt_inc_s = cnt_q + CNT_ONE;

  // Next-state, period counter and done pulse; stop > start > arm > trigger
  always_comb begin
    state_d   = state_q;
    cnt_nxt_s = cnt_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_stop_i) begin
          state_d = S_IDLE;
        end else if (cmd_start_i) begin
          state_d   = S_RUN;
          cnt_nxt_s = CNT_ZERO;
        end else if (cmd_arm_i) begin
          state_d = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        if (cmd_stop_i) begin
          state_d = S_IDLE;
        end else if (cmd_start_i || trig_i) begin
          state_d   = S_RUN;
          cnt_nxt_s = CNT_ZERO;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_RUN: begin
        if (cmd_stop_i) begin
          state_d = S_IDLE;
        end else if (counter_end_i && !cmd_reset_i) begin
          // A repeat value below the current count only matches again after wrap
          cnt_nxt_s = cnt_inc_s;
          if ((cfg_repeat_i != CNT_ZERO) && (cnt_inc_s == cfg_repeat_i)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    cnt_d    = cmd_reset_i ? CNT_ZERO : cnt_nxt_s;
    active_d = (state_d == S_RUN);
  end

  // Output and state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      active_q <= 1'b0;
      update_q <= 1'b0;
      rst_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      update_q <= cmd_update_i;
      rst_q    <= cmd_reset_i;
      done_q   <= done_d;
    end
  end

  assign ctrl_active_o = active_q;
  assign ctrl_update_o = update_q;
  assign ctrl_rst_o    = rst_q;
  assign state_o       = state_q;
  assign period_cnt_o  = cnt_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_adv_timer_sequencer.sv
// Self-checking bench for adv_timer_sequencer: directed scenarios plus random
// command traffic, every cycle compared against a rule-level reference model.
module tb_adv_timer_sequencer;

  localparam int RB = 8;

  localparam logic [6:0] C_START = 7'b0000001;
  localparam logic [6:0] C_STOP  = 7'b0000010;
  localparam logic [6:0] C_ARM   = 7'b0000100;
  localparam logic [6:0] C_UPD   = 7'b0001000;
  localparam logic [6:0] C_RST   = 7'b0010000;
  localparam logic [6:0] C_TRIG  = 7'b0100000;
  localparam logic [6:0] C_END   = 7'b1000000;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_RUN  = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_start, cmd_stop, cmd_arm, cmd_update, cmd_reset, trig, cnt_end;
  logic [RB-1:0] cfg_repeat;
  logic          ctrl_active, ctrl_update, ctrl_rst, done;
  logic [1:0]    state;
  logic [RB-1:0] period_cnt;

  int checks   = 0;
  int failures = 0;

  int m_state = M_IDLE;
  int m_cnt   = 0;
  bit m_done  = 1'b0;
  bit m_upd   = 1'b0;
  bit m_rst   = 1'b0;

  always #5 clk = ~clk;

  adv_timer_sequencer #(.RPT_BITS(RB)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .cmd_start_i  (cmd_start),
    .cmd_stop_i   (cmd_stop),
    .cmd_arm_i    (cmd_arm),
    .cmd_update_i (cmd_update),
    .cmd_reset_i  (cmd_reset),
    .trig_i       (trig),
    .counter_end_i(cnt_end),
    .cfg_repeat_i (cfg_repeat),
    .ctrl_active_o(ctrl_active),
    .ctrl_update_o(ctrl_update),
    .ctrl_rst_o   (ctrl_rst),
    .state_o      (state),
    .period_cnt_o (period_cnt),
    .done_o       (done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: applies the command rules to the inputs seen at one clock edge
  task automatic model_edge();
    int nxt;
    int cnt;
    if (!rstn) begin
      m_state = M_IDLE; m_cnt = 0; m_done = 1'b0; m_upd = 1'b0; m_rst = 1'b0;
    end else begin
      nxt    = m_state;
      cnt    = m_cnt;
      m_done = 1'b0;
      m_upd  = cmd_update;
      m_rst  = cmd_reset;
      if (cmd_stop) begin
        nxt = M_IDLE;
      end else if (cmd_start && m_state != M_RUN) begin
        nxt = M_RUN; cnt = 0;
      end else if (cmd_arm && m_state == M_IDLE) begin
        nxt = M_ARM;
      end else if (trig && m_state == M_ARM) begin
        nxt = M_RUN; cnt = 0;
      end else if (cnt_end && m_state == M_RUN && !cmd_reset) begin
        cnt = (cnt + 1) % (1 << RB);
        if (int'(cfg_repeat) != 0 && cnt == int'(cfg_repeat)) begin
          nxt = M_IDLE; m_done = 1'b1;
        end
      end
      if (cmd_reset) cnt = 0;
      m_state = nxt;
      m_cnt   = cnt;
    end
  endtask

  task automatic cyc(input logic [6:0] c);
    cmd_start  = c[0];
    cmd_stop   = c[1];
    cmd_arm    = c[2];
    cmd_update = c[3];
    cmd_reset  = c[4];
    trig       = c[5];
    cnt_end    = c[6];
    @(posedge clk);
    model_edge();
    #1;
    check_val("state",  32'(state),       32'(m_state));
    check_val("active", 32'(ctrl_active), 32'(m_state == M_RUN));
    check_val("count",  32'(period_cnt),  32'(m_cnt));
    check_val("done",   32'(done),        32'(m_done));
    check_val("update", 32'(ctrl_update), 32'(m_upd));
    check_val("rst",    32'(ctrl_rst),    32'(m_rst));
  endtask

  initial begin
    logic [6:0] c;
    rstn = 1'b0;
    cfg_repeat = 8'd0;

    // Reset held with start asserted
    cyc(C_START);
    cyc(C_START);
    check_val("rst_state", 32'(state), 32'd0);
    check_val("rst_active", 32'(ctrl_active), 32'd0);
    rstn = 1'b1;
    cyc(C_START);
    check_val("start_active", 32'(ctrl_active), 32'd1);

    // Repeat auto-stop after three periods
    cyc(C_STOP);
    cfg_repeat = 8'd3;
    cyc(C_START);
    for (int i = 1; i <= 3; i++) begin
      cyc(C_END);
      check_val("rpt_cnt", 32'(period_cnt), 32'(i));
    end
    check_val("rpt_done", 32'(done), 32'd1);
    check_val("rpt_state", 32'(state), 32'd0);
    cyc(7'b0);
    check_val("rpt_done_off", 32'(done), 32'd0);
    check_val("rpt_hold", 32'(period_cnt), 32'd3);

    // Arm / trigger, and trigger ignored after disarm
    cyc(C_ARM);
    check_val("armed", 32'(state), 32'd1);
    cyc(C_TRIG);
    check_val("trig_run", 32'(state), 32'd2);
    cyc(C_STOP);
    cyc(C_ARM);
    cyc(C_STOP);
    cyc(C_TRIG);
    check_val("trig_ignored", 32'(state), 32'd0);

    // Free-run wrap
    cfg_repeat = 8'd0;
    cyc(C_START);
    for (int i = 0; i < 256; i++) cyc(C_END);
    check_val("wrap_cnt", 32'(period_cnt), 32'd0);
    check_val("wrap_state", 32'(state), 32'd2);

    // Collisions in RUN
    cyc(C_END);
    cyc(C_STOP | C_END);
    check_val("stop_end_cnt", 32'(period_cnt), 32'd1);
    cfg_repeat = 8'd1;
    cyc(C_START);
    cyc(C_RST | C_END);
    check_val("rst_end_state", 32'(state), 32'd2);
    check_val("rst_end_pulse", 32'(ctrl_rst), 32'd1);

    // Update/reset pulses across states
    cyc(C_STOP);
    cyc(C_UPD);
    cyc(C_ARM);
    cyc(C_UPD);
    cyc(C_START);
    cyc(C_UPD);
    cyc(C_RST);
    cyc(C_UPD | C_RST);
    cyc(7'b0);

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      c = 7'b0;
      c[0] = ($urandom_range(99) < 5);
      c[1] = ($urandom_range(99) < 3);
      c[2] = ($urandom_range(99) < 5);
      c[3] = ($urandom_range(99) < 10);
      c[4] = ($urandom_range(99) < 3);
      c[5] = ($urandom_range(99) < 8);
      c[6] = ($urandom_range(99) < 35);
      if ($urandom_range(99) < 4) cfg_repeat = RB'($urandom_range(6));
      rstn = ($urandom_range(999) >= 5);
      cyc(c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
